// File: rtl/latched_modifier_pkg.sv
// Shared types for the latched modifier bank.
// Request fields are sized to the widest supported channel/magnitude.
package latched_modifier_pkg;

    localparam int REQ_N_MAX  = 32;
    localparam int REQ_CW_MAX = 8;

    typedef enum logic {
        MODE_LOAD  = 1'b0,
        MODE_ACCUM = 1'b1
    } mode_e;

    typedef struct packed {
        logic [REQ_CW_MAX-1:0] ch;
        mode_e                 mode;
        logic [REQ_N_MAX-1:0]  mag;
        logic                  sgn;
        logic                  valid;
    } req_t;

endpackage

// File: rtl/sm_sat_adder.sv
// Saturating sign-magnitude adder with zero canonicalisation.
// Operand a is the stored value, operand b the modifier.
module sm_sat_adder #(
    parameter int N = 8
) (
    input  logic [N-1:0] a_mag,
    input  logic         a_sgn,
    input  logic [N-1:0] b_mag,
    input  logic         b_sgn,
    output logic [N-1:0] r_mag,
    output logic         r_sgn,
    output logic         sat
);

    logic [N:0] sum;

    always_comb begin
        sum   = {1'b0, a_mag} + {1'b0, b_mag};
        r_mag = a_mag;
        r_sgn = a_sgn;
        sat   = 1'b0;
        if (a_sgn == b_sgn) begin
            if (sum[N]) begin
                r_mag = '1;
                sat   = 1'b1;
            end else begin
                r_mag = sum[N-1:0];
            end
        end else if (b_mag > a_mag) begin
            r_mag = b_mag - a_mag;
            r_sgn = b_sgn;
        end else begin
            r_mag = a_mag - b_mag;
        end
        if (r_mag == '0) begin
            r_sgn = 1'b0;
        end
    end

endmodule

// File: rtl/latched_modifier_bank.sv
// Multi-channel sign-magnitude modifier register bank.
// Three-stage request/compute/write-back pipeline with S3->S2 forwarding.
module latched_modifier_bank
    import latched_modifier_pkg::*;
#(
    parameter int N   = 8,
    parameter int NCH = 4,
    parameter int CW  = 2
) (
    input  logic             CLK,
    input  logic             INIT,
    input  logic [N-1:0]     INITIAL_VALUE,
    input  logic             INITIAL_SIGN,
    input  logic             EN,
    input  logic             TRIG,
    input  logic [CW-1:0]    CH_SEL,
    input  logic             MODE,
    input  logic [N-1:0]     MODIFIER,
    input  logic             SIGN_MODIFIER,
    output logic [NCH*N-1:0] OUT_BUS,
    output logic [NCH-1:0]   SIGN_BUS,
    output logic [NCH-1:0]   SAT_FLAGS,
    output logic             DONE,
    output logic [CW-1:0]    DONE_CH
);

    logic [N-1:0]   mag_q [NCH];
    logic [NCH-1:0] sgn_q;
    logic [NCH-1:0] sat_q;

    req_t           s1_q;
    req_t           s1_d;
    logic           accept;

    logic           s2_valid_q;
    logic [CW-1:0]  s2_ch_q;
    logic [N-1:0]   s2_mag_q;
    logic           s2_sgn_q;
    logic           s2_sat_q;

    logic           done_q;
    logic [CW-1:0]  done_ch_q;

    logic [CW-1:0]  s1_ch;
    logic [N-1:0]   s1_mod;
    logic           fwd;
    logic [N-1:0]   cur_mag;
    logic           cur_sgn;
    logic [N-1:0]   acc_mag;
    logic           acc_sgn;
    logic           acc_sat;
    logic [N-1:0]   nxt_mag;
    logic           nxt_sgn;
    logic           nxt_sat;

    // Out-of-range channels never enter the pipeline.
    assign accept = TRIG & EN & ~INIT & (int'(CH_SEL) < NCH);

    always_comb begin
        s1_d       = '0;
        s1_d.ch    = REQ_CW_MAX'(CH_SEL);
        s1_d.mode  = mode_e'(MODE);
        s1_d.mag   = REQ_N_MAX'(MODIFIER);
        s1_d.sgn   = SIGN_MODIFIER;
        s1_d.valid = accept;
    end

    assign s1_ch  = CW'(s1_q.ch);
    assign s1_mod = N'(s1_q.mag);

    // The write-back in flight this cycle is newer than the register file.
    always_comb begin
        fwd     = s2_valid_q && (s2_ch_q == s1_ch);
        cur_mag = fwd ? s2_mag_q : mag_q[s1_ch];
        cur_sgn = fwd ? s2_sgn_q : sgn_q[s1_ch];
    end

    sm_sat_adder #(
        .N(N)
    ) u_adder (
        .a_mag(cur_mag),
        .a_sgn(cur_sgn),
        .b_mag(s1_mod),
        .b_sgn(s1_q.sgn),
        .r_mag(acc_mag),
        .r_sgn(acc_sgn),
        .sat  (acc_sat)
    );

    always_comb begin
        nxt_mag = acc_mag;
        nxt_sgn = acc_sgn;
        nxt_sat = acc_sat;
        unique case (s1_q.mode)
            MODE_LOAD: begin
                nxt_mag = s1_mod;
                nxt_sgn = s1_q.sgn & (|s1_mod);
                nxt_sat = 1'b0;
            end
            MODE_ACCUM: begin
                nxt_mag = acc_mag;
                nxt_sgn = acc_sgn;
                nxt_sat = acc_sat;
            end
            default: begin
                nxt_mag = acc_mag;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (INIT) begin
            for (int i = 0; i < NCH; i++) begin
                mag_q[i] <= INITIAL_VALUE;
            end
            sgn_q      <= {NCH{INITIAL_SIGN & (|INITIAL_VALUE)}};
            sat_q      <= '0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            s2_ch_q    <= '0;
            s2_mag_q   <= '0;
            s2_sgn_q   <= 1'b0;
            s2_sat_q   <= 1'b0;
            done_q     <= 1'b0;
            done_ch_q  <= '0;
        end else begin
            s1_q       <= s1_d;
            s2_valid_q <= s1_q.valid;
            s2_ch_q    <= s1_ch;
            s2_mag_q   <= nxt_mag;
            s2_sgn_q   <= nxt_sgn;
            s2_sat_q   <= nxt_sat;
            done_q     <= s2_valid_q;
            if (s2_valid_q) begin
                mag_q[s2_ch_q] <= s2_mag_q;
                sgn_q[s2_ch_q] <= s2_sgn_q;
                sat_q[s2_ch_q] <= sat_q[s2_ch_q] | s2_sat_q;
                done_ch_q      <= s2_ch_q;
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_bus
        assign OUT_BUS[i*N +: N] = mag_q[i];
    end

    assign SIGN_BUS  = sgn_q;
    assign SAT_FLAGS = sat_q;
    assign DONE      = done_q;
    assign DONE_CH   = done_ch_q;

endmodule

// File: tb/tb_latched_modifier_bank.sv
// Scoreboard bench for latched_modifier_bank.
// Reference model works on signed integers; monitor checks every cycle.
module tb_latched_modifier_bank;

    localparam int N   = 8;
    localparam int NCH = 4;
    localparam int CW  = 3;
    localparam int MAXV = (1 << N) - 1;

    logic             CLK = 1'b0;
    logic             INIT = 1'b0;
    logic [N-1:0]     INITIAL_VALUE = '0;
    logic             INITIAL_SIGN = 1'b0;
    logic             EN = 1'b0;
    logic             TRIG = 1'b0;
    logic [CW-1:0]    CH_SEL = '0;
    logic             MODE = 1'b0;
    logic [N-1:0]     MODIFIER = '0;
    logic             SIGN_MODIFIER = 1'b0;
    logic [NCH*N-1:0] OUT_BUS;
    logic [NCH-1:0]   SIGN_BUS;
    logic [NCH-1:0]   SAT_FLAGS;
    logic             DONE;
    logic [CW-1:0]    DONE_CH;

    latched_modifier_bank #(
        .N  (N),
        .NCH(NCH),
        .CW (CW)
    ) dut (
        .CLK          (CLK),
        .INIT         (INIT),
        .INITIAL_VALUE(INITIAL_VALUE),
        .INITIAL_SIGN (INITIAL_SIGN),
        .EN           (EN),
        .TRIG         (TRIG),
        .CH_SEL       (CH_SEL),
        .MODE         (MODE),
        .MODIFIER     (MODIFIER),
        .SIGN_MODIFIER(SIGN_MODIFIER),
        .OUT_BUS      (OUT_BUS),
        .SIGN_BUS     (SIGN_BUS),
        .SAT_FLAGS    (SAT_FLAGS),
        .DONE         (DONE),
        .DONE_CH      (DONE_CH)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int ch;
        int mag;
        bit sgn;
        bit sat;
        int due;
    } exp_t;

    exp_t q[$];

    // Predicted state (requests applied in order of acceptance).
    int pm [NCH];
    bit ps [NCH];
    bit pf [NCH];
    // Committed state (what the outputs should show right now).
    int cm [NCH];
    bit cs [NCH];
    bit cf [NCH];

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    bit started = 0;

    task automatic chk(string name, int act, int expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d",
                     name, cyc, act, expv);
        end
    endtask

    function automatic void apply(int ch, bit mode, int mod, bit s);
        int v;
        int r;
        if (!mode) begin
            pm[ch] = mod;
            ps[ch] = s;
        end else if (ps[ch] == s) begin
            r = pm[ch] + mod;
            if (r > MAXV) begin
                r = MAXV;
                pf[ch] = 1'b1;
            end
            pm[ch] = r;
        end else begin
            v = ps[ch] ? -pm[ch] : pm[ch];
            r = v + (s ? -mod : mod);
            pm[ch] = (r < 0) ? -r : r;
            ps[ch] = (r < 0);
        end
        if (pm[ch] == 0) ps[ch] = 1'b0;
    endfunction

    // Model side: observe what the DUT samples at each edge.
    always @(posedge CLK) begin
        exp_t e;
        cyc++;
        if (INIT) begin
            q.delete();
            for (int i = 0; i < NCH; i++) begin
                pm[i] = int'(INITIAL_VALUE);
                ps[i] = INITIAL_SIGN && (INITIAL_VALUE != 0);
                pf[i] = 1'b0;
                cm[i] = pm[i];
                cs[i] = ps[i];
                cf[i] = 1'b0;
            end
            started = 1'b1;
        end else if (TRIG && EN && int'(CH_SEL) < NCH) begin
            apply(int'(CH_SEL), MODE, int'(MODIFIER), SIGN_MODIFIER);
            e.ch  = int'(CH_SEL);
            e.mag = pm[e.ch];
            e.sgn = ps[e.ch];
            e.sat = pf[e.ch];
            e.due = cyc + 2;
            q.push_back(e);
        end
    end

    // Monitor: pop on DONE, then compare the whole visible state.
    always @(negedge CLK) begin
        exp_t e;
        if (started) begin
            if (q.size() != 0 && q[0].due == cyc) begin
                e = q.pop_front();
                chk("done", int'(DONE), 1);
                chk("done_ch", int'(DONE_CH), e.ch);
                cm[e.ch] = e.mag;
                cs[e.ch] = e.sgn;
                cf[e.ch] = e.sat;
            end else begin
                chk("done_idle", int'(DONE), 0);
            end
            for (int i = 0; i < NCH; i++) begin
                chk($sformatf("mag%0d", i), int'(OUT_BUS[i*N +: N]), cm[i]);
                chk($sformatf("sgn%0d", i), int'(SIGN_BUS[i]), int'(cs[i]));
                chk($sformatf("sat%0d", i), int'(SAT_FLAGS[i]), int'(cf[i]));
            end
        end
    end

    task automatic req(int ch, bit mode, int mod, bit s, bit en = 1'b1);
        CH_SEL        = CW'(ch);
        MODE          = mode;
        MODIFIER      = N'(mod);
        SIGN_MODIFIER = s;
        EN            = en;
        TRIG          = 1'b1;
        @(posedge CLK);
        #1;
        TRIG = 1'b0;
        EN   = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic do_init(int v, bit s);
        INIT          = 1'b1;
        INITIAL_VALUE = N'(v);
        INITIAL_SIGN  = s;
        @(posedge CLK);
        #1;
        INIT = 1'b0;
    endtask

    initial begin
        idle(1);
        do_init('h10, 1'b1);
        idle(2);

        req(2, 1'b0, 'h7F, 1'b0);
        idle(3);

        req(0, 1'b0, 'hF0, 1'b0);
        idle(3);
        req(0, 1'b1, 'h20, 1'b0);
        idle(3);
        req(0, 1'b0, 'h01, 1'b0);
        idle(3);

        req(1, 1'b0, 'h10, 1'b0);
        idle(3);
        req(1, 1'b1, 'h30, 1'b1);
        idle(3);
        req(1, 1'b1, 'h20, 1'b0);
        idle(3);

        req(3, 1'b0, 'h00, 1'b0);
        idle(3);
        req(3, 1'b1, 5, 1'b0);
        req(3, 1'b1, 7, 1'b0);
        req(3, 1'b1, 3, 1'b1);
        idle(3);

        req(NCH, 1'b0, 'h55, 1'b1);
        req(7, 1'b1, 'h11, 1'b0);
        req(1, 1'b0, 'h66, 1'b0, 1'b0);
        idle(3);

        req(2, 1'b0, 'h33, 1'b0);
        do_init('h10, 1'b1);
        idle(3);

        req(0, 1'b1, 'h01, 1'b0);
        req(1, 1'b1, 'h02, 1'b1);
        do_init('h00, 1'b1);
        idle(3);

        for (int k = 0; k < 500; k++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_init($urandom_range(0, MAXV), 1'($urandom_range(0, 1)));
            end else if ($urandom_range(0, 3) != 0) begin
                req($urandom_range(0, 5),
                    1'($urandom_range(0, 2) != 0),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(200, MAXV)
                                                : $urandom_range(0, 40),
                    1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 7) != 0));
            end else begin
                idle(1);
            end
        end

        idle(5);
        chk("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
